// File: rtl/mix_b_update_if.sv
`default_nettype none
// ============================================================================
// Module      : mix_b_update_if
// Description : Bundles the mix_b_update control, bias/gradient read and
//               bias write-back signals. "master" is the optimizer stage;
//               "slave" is the environment (controller plus RAMs).
// Revision    : 1.0  initial release
// ============================================================================
interface mix_b_update_if #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 18
);
    logic                  start;
    logic [1:0]            bank_sel;
    logic                  busy;
    logic                  done;
    logic [ADDR_WIDTH-1:0] raddr;
    logic [DATA_WIDTH-1:0] rdata;
    logic [ADDR_WIDTH-1:0] grad_raddr;
    logic [DATA_WIDTH-1:0] grad_rdata;
    logic                  load;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;

    modport master (
        input  start, bank_sel, rdata, grad_rdata,
        output busy, done, raddr, grad_raddr, load, waddr, wdata
    );

    modport slave (
        output start, bank_sel, rdata, grad_rdata,
        input  busy, done, raddr, grad_raddr, load, waddr, wdata
    );
endinterface
`default_nettype wire

// File: rtl/mix_b_update.sv
`default_nettype none
// ============================================================================
// Module      : mix_b_update
// Description : SGD write-back for the mix-layer bias RAM. Sweeps one bank
//               (or all three), reads bias and gradient, writes back
//               sat(bias - (grad >>> LR_SHIFT)).
//               Optional macro MIX_B_CLIP_EN clamps the gradient to
//               [-GRAD_CLIP, GRAD_CLIP] before the shift.
// Revision    : 1.0  initial release
// ============================================================================
`ifndef N_LEN_W
`define N_LEN_W 18
`endif
`ifndef HID_DIM
`define HID_DIM 16
`endif

module mix_b_update #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = `N_LEN_W,
    parameter int BANK_DEPTH = `HID_DIM,
    parameter int LR_SHIFT   = 4,
    parameter int GRAD_CLIP  = 2**(`N_LEN_W-3)
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    mix_b_update_if.master bus
);

`ifdef MIX_B_CLIP_EN
    localparam bit c_CLIP_EN = 1'b1;
`else
    localparam bit c_CLIP_EN = 1'b0;
`endif

    localparam logic [ADDR_WIDTH-1:0] c_BANK1 = ADDR_WIDTH'(BANK_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] c_BANK2 = ADDR_WIDTH'(2 * BANK_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] c_LAST0 = ADDR_WIDTH'(BANK_DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] c_LAST1 = ADDR_WIDTH'(2 * BANK_DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] c_LAST2 = ADDR_WIDTH'(3 * BANK_DEPTH - 1);

    localparam logic signed [DATA_WIDTH-1:0] c_CLIP_POS = DATA_WIDTH'(GRAD_CLIP);
    localparam logic signed [DATA_WIDTH-1:0] c_CLIP_NEG = -c_CLIP_POS;
    localparam logic [DATA_WIDTH-1:0] c_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] c_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [ADDR_WIDTH-1:0]   r_last;
    logic                    r_drain;
    logic                    r_v1;
    logic [ADDR_WIDTH-1:0]   r_a1;
    logic                    r_load;
    logic [ADDR_WIDTH-1:0]   r_waddr;
    logic [DATA_WIDTH-1:0]   r_wdata;

    logic [ADDR_WIDTH-1:0]   w_base;
    logic [ADDR_WIDTH-1:0]   w_last;
    logic                    w_busy;
    logic                    w_done;
    logic signed [DATA_WIDTH-1:0] w_grad;
    logic signed [DATA_WIDTH-1:0] w_step;
    logic [DATA_WIDTH:0]     w_diff;
    logic [DATA_WIDTH-1:0]   w_sat;

    // Address window selected by bank_sel; 3 means the whole three-bank span
    always_comb begin
        w_base = '0;
        w_last = c_LAST0;
        case (bus.bank_sel)
            2'd1:    begin w_base = c_BANK1; w_last = c_LAST1; end
            2'd2:    begin w_base = c_BANK2; w_last = c_LAST2; end
            2'd3:    begin w_base = '0;      w_last = c_LAST2; end
            default: begin w_base = '0;      w_last = c_LAST0; end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next state and status outputs; start outside IDLE is simply dropped
    always_comb begin
        w_next = r_state;
        w_busy = 1'b1;
        w_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (bus.start) w_next = S_READ;
            end
            S_READ:  if (r_addr == r_last) w_next = S_DRAIN;
            S_DRAIN: if (r_drain) w_next = S_DONE;
            S_DONE: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Sweep address, drain timer and the read-to-write delay line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr  <= '0;
            r_last  <= '0;
            r_drain <= 1'b0;
            r_v1    <= 1'b0;
            r_a1    <= '0;
        end else begin
            if (r_state == S_IDLE && bus.start) begin
                r_addr <= w_base;
                r_last <= w_last;
            end else if (r_state == S_READ && r_addr != r_last) begin
                r_addr <= r_addr + 1'b1;
            end
            r_drain <= (r_state == S_DRAIN) && !r_drain;
            r_v1    <= (r_state == S_READ);
            r_a1    <= r_addr;
        end
    end

    // SGD step: optional clamp, arithmetic shift, widened subtract, saturate
    always_comb begin
        w_grad = $signed(bus.grad_rdata);
        if (c_CLIP_EN) begin
            if (w_grad > c_CLIP_POS)      w_grad = c_CLIP_POS;
            else if (w_grad < c_CLIP_NEG) w_grad = c_CLIP_NEG;
        end
        w_step = w_grad >>> LR_SHIFT;
        w_diff = {bus.rdata[DATA_WIDTH-1], bus.rdata}
               - {w_step[DATA_WIDTH-1], w_step};
        w_sat  = w_diff[DATA_WIDTH-1:0];
        if (w_diff[DATA_WIDTH] != w_diff[DATA_WIDTH-1])
            w_sat = w_diff[DATA_WIDTH] ? c_MIN : c_MAX;
    end

    // Write-back register stage feeding the bias RAM write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_load  <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else begin
            r_load <= r_v1;
            if (r_v1) begin
                r_waddr <= r_a1;
                r_wdata <= w_sat;
            end
        end
    end

    assign bus.busy       = w_busy;
    assign bus.done       = w_done;
    assign bus.raddr      = r_addr;
    assign bus.grad_raddr = r_addr;
    assign bus.load       = r_load;
    assign bus.waddr      = r_waddr;
    assign bus.wdata      = r_wdata;

endmodule
`default_nettype wire

// File: doc/mix_b_update.md
Name: mix_b_update

Overview:
- Optimizer write-back stage for the mix-layer bias RAM in the training path; sits directly upstream of the bias RAM's write port.
- On a start pulse it sweeps one bias bank (or all three) and reads the current bias and the accumulated gradient for each address.
- It computes an SGD step, bias - (grad >>> LR_SHIFT), with saturation, and streams the result back through the RAM's load/waddr/wdata port.
- Reads go through the RAM's registered read port (raddr/rdata, 1-cycle latency).

Parameters:
- ADDR_WIDTH, 9, address width of the bias RAM and the gradient buffer.
- DATA_WIDTH, `N_LEN_W, signed two's-complement width of both bias and gradient words.
- BANK_DEPTH, `HID_DIM, words per bias bank (three banks: b_1, b_2, b_3).
- LR_SHIFT, 4, learning rate expressed as an arithmetic right shift of the gradient.
- GRAD_CLIP, 2**(`N_LEN_W-3), magnitude limit used only when MIX_B_CLIP_EN is defined.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; sampled only while idle
- bank_sel  in  2  bank to update: 0..2 updates one bank; 3 updates all three
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse after the last write
- raddr  out  ADDR_WIDTH  bias RAM read address
- rdata  in  DATA_WIDTH  bias RAM read data, valid one cycle after raddr
- grad_raddr  out  ADDR_WIDTH  gradient buffer read address; always equals raddr
- grad_rdata  in  DATA_WIDTH  gradient word, valid one cycle after grad_raddr
- load  out  1  bias RAM write enable
- waddr  out  ADDR_WIDTH  bias RAM write address
- wdata  out  DATA_WIDTH  updated bias

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - busy, done, load = 0; raddr, grad_raddr, waddr, wdata = 0.
  - Reset mid-sweep aborts immediately. Already-written words keep their updated values; no further writes occur.
- Address range:
  - base = bank_sel*BANK_DEPTH; last = base+BANK_DEPTH-1.
  - When bank_sel=3: base = 0 and last = 3*BANK_DEPTH-1.
  - bank_sel is captured at start and ignored afterwards.
- State machine:
  - IDLE: start=1 at edge E0 loads addr<=base, sets busy, and goes to READ.
  - READ: raddr=addr. Each edge increments addr. At the edge where addr==last, go to DRAIN.
  - DRAIN: hold for 2 cycles so the final read and its write complete, then go to DONE.
  - DONE: done=1 for one cycle, busy<=0, return to IDLE.
- Pipeline:
  - Stage 1: issue raddr/grad_raddr; registered address delay line a1 <= raddr.
  - Stage 2: rdata and grad_rdata are valid. At the next edge register load<=1, waddr<=a1, wdata<=sat(rdata - (grad_rdata >>> LR_SHIFT)).
  - First load is visible in the cycle after E2 (start at E0, first raddr issued in the cycle after E0).
  - Exactly N loads are produced, each address exactly once, in ascending order, with no gaps. N = BANK_DEPTH, or 3*BANK_DEPTH when bank_sel=3.
  - done rises the cycle after the last load.
- Arithmetic:
  - Subtraction is done at DATA_WIDTH+1 bits, then saturated to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - The shift is arithmetic, so it rounds toward -inf.
- Hazards: each address is read before its own write and never re-read, so no read/write forwarding is needed.
- Simultaneous events: start asserted while busy=1, or in the same cycle as done, is ignored and not queued.
- Outside an update: load=0 whenever not writing; raddr holds its last value when idle.

Optional Feature:
- Macro: MIX_B_CLIP_EN.
- Defined: the gradient is clamped to [-GRAD_CLIP, GRAD_CLIP] before the shift. Latency is unchanged, with the clamp in the same stage.
- Undefined: no clamp is applied, and the GRAD_CLIP parameter is unused.

Test Plan:
- Basic step: DATA_WIDTH=18, LR_SHIFT=4, bank_sel=0, bias[0]=256, grad[0]=512 -> load with waddr=0, wdata=224; 256-(512>>>4)=224.
- Negative gradient: bias=-100, grad=-33 -> wdata=-100-(-3)=-97 (arithmetic shift rounds toward -inf).
- Saturation: bias=18'h20000, grad=18'h1FFFF -> wdata=18'h20000. Separately, bias=18'h1FFFF, grad=18'h20000 -> wdata=18'h1FFFF.
- Full sweep: bank_sel=3 -> exactly 3*BANK_DEPTH loads, addresses 0..3*BANK_DEPTH-1 contiguous, one done pulse; bank_sel=2 -> addresses 2*BANK_DEPTH..3*BANK_DEPTH-1 only.
- Control: start pulsed mid-sweep -> no restart and load count unchanged. rst_n=0 mid-sweep -> load=0 and busy=0 immediately; restart after reset completes a correct sweep.
- With MIX_B_CLIP_EN: grad=2**16, GRAD_CLIP=2**15, bias=0 -> wdata=-2048. Without the macro -> wdata=-4096.
